// File: rtl/lsu_ctrl_if.sv
// Handshake bundle around lsu_ctrl: EXU op offer, memory request/response port and WBU result.
// The slave modport is the LSU's view; the master modport is the surrounding pipeline/memory.
interface lsu_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  i_exu_valid;
  logic                  o_lsu_ready;
  logic                  i_idu_ctr_ram_r_en;
  logic                  i_idu_ctr_ram_w_en;
  logic [2:0]            i_idu_ctr_ram_byt;
  logic [ADDR_WIDTH-1:0] i_exu_res;
  logic [DATA_WIDTH-1:0] i_gpr_rs2_data;

  logic                  o_ram_req_valid;
  logic                  i_ram_req_ready;
  logic [ADDR_WIDTH-1:0] o_ram_addr;
  logic                  o_ram_wr_en;
  logic [3:0]            o_ram_wr_mask;
  logic [DATA_WIDTH-1:0] o_ram_wr_data;
  logic                  i_ram_resp_valid;
  logic [DATA_WIDTH-1:0] i_ram_resp_data;
  logic                  o_ram_resp_ready;

  logic                  o_lsu_valid;
  logic                  i_wbu_ready;
  logic [DATA_WIDTH-1:0] o_lsu_res;
  logic                  o_lsu_misalign;

  modport slave (
    input  i_exu_valid, i_idu_ctr_ram_r_en, i_idu_ctr_ram_w_en, i_idu_ctr_ram_byt,
           i_exu_res, i_gpr_rs2_data, i_ram_req_ready, i_ram_resp_valid,
           i_ram_resp_data, i_wbu_ready,
    output o_lsu_ready, o_ram_req_valid, o_ram_addr, o_ram_wr_en, o_ram_wr_mask,
           o_ram_wr_data, o_ram_resp_ready, o_lsu_valid, o_lsu_res, o_lsu_misalign
  );

  modport master (
    output i_exu_valid, i_idu_ctr_ram_r_en, i_idu_ctr_ram_w_en, i_idu_ctr_ram_byt,
           i_exu_res, i_gpr_rs2_data, i_ram_req_ready, i_ram_resp_valid,
           i_ram_resp_data, i_wbu_ready,
    input  o_lsu_ready, o_ram_req_valid, o_ram_addr, o_ram_wr_en, o_ram_wr_mask,
           o_ram_wr_data, o_ram_resp_ready, o_lsu_valid, o_lsu_res, o_lsu_misalign
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store stage between EXU and WBU: one op at a time through IDLE/REQ/RESP/DONE,
// with byte-lane alignment, store strobes, load extension and misalignment detection.
module lsu_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic       i_clk,
  input logic       i_rst,
  lsu_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Undefined size codes collapse onto a full word access.
  function automatic logic [1:0] sizeOf(input logic [2:0] byt);
    case (byt)
      3'b000, 3'b100: sizeOf = SZ_B;
      3'b001, 3'b101: sizeOf = SZ_H;
      default:        sizeOf = SZ_W;
    endcase
  endfunction

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]            byt_q, byt_d;
  logic                  load_q, load_d;
  logic                  store_q, store_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                  misalign_q, misalign_d;

  logic [1:0]            inSize;
  logic                  inMemOp;
  logic                  inMisalign;
  logic [4:0]            shamt;
  logic [DATA_WIDTH-1:0] rdShifted;
  logic [DATA_WIDTH-1:0] loadExt;
  logic [3:0]            storeMask;

  assign inSize     = sizeOf(bus.i_idu_ctr_ram_byt);
  assign inMemOp    = bus.i_idu_ctr_ram_r_en | bus.i_idu_ctr_ram_w_en;
  assign inMisalign = ((inSize == SZ_H) && bus.i_exu_res[0]) ||
                      ((inSize == SZ_W) && (bus.i_exu_res[1:0] != 2'b00));
  assign shamt      = {addr_q[1:0], 3'b000};

  // Bit 2 of the size code marks the unsigned variants.
  always_comb begin
    rdShifted = bus.i_ram_resp_data >> shamt;
    case (sizeOf(byt_q))
      SZ_B:    loadExt = {{(DATA_WIDTH-8){~byt_q[2] & rdShifted[7]}}, rdShifted[7:0]};
      SZ_H:    loadExt = {{(DATA_WIDTH-16){~byt_q[2] & rdShifted[15]}}, rdShifted[15:0]};
      default: loadExt = rdShifted;
    endcase
  end

  always_comb begin
    case (sizeOf(byt_q))
      SZ_B:    storeMask = 4'b0001 << addr_q[1:0];
      SZ_H:    storeMask = 4'b0011 << addr_q[1:0];
      default: storeMask = 4'b1111;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      byt_q      <= '0;
      load_q     <= 1'b0;
      store_q    <= 1'b0;
      res_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      byt_q      <= byt_d;
      load_q     <= load_d;
      store_q    <= store_d;
      res_q      <= res_d;
      misalign_q <= misalign_d;
    end
  end

  // A simultaneous load+store request is handled as a load.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    byt_d      = byt_q;
    load_d     = load_q;
    store_d    = store_q;
    res_d      = res_q;
    misalign_d = misalign_q;
    case (state_q)
      IDLE: begin
        if (bus.i_exu_valid) begin
          addr_d     = bus.i_exu_res;
          wdata_d    = bus.i_gpr_rs2_data;
          byt_d      = bus.i_idu_ctr_ram_byt;
          load_d     = bus.i_idu_ctr_ram_r_en;
          store_d    = bus.i_idu_ctr_ram_w_en & ~bus.i_idu_ctr_ram_r_en;
          res_d      = '0;
          misalign_d = inMemOp & inMisalign;
          state_d    = (inMemOp && !inMisalign) ? REQ : DONE;
        end
      end
      REQ: begin
        if (bus.i_ram_req_ready) state_d = RESP;
      end
      RESP: begin
        if (bus.i_ram_resp_valid) begin
          res_d   = load_q ? loadExt : '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.i_wbu_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.o_lsu_ready      = (state_q == IDLE);
    bus.o_ram_req_valid  = 1'b0;
    bus.o_ram_addr       = '0;
    bus.o_ram_wr_en      = 1'b0;
    bus.o_ram_wr_mask    = 4'b0000;
    bus.o_ram_wr_data    = '0;
    bus.o_ram_resp_ready = (state_q == RESP);
    bus.o_lsu_valid      = 1'b0;
    bus.o_lsu_res        = '0;
    bus.o_lsu_misalign   = 1'b0;
    if (state_q == REQ) begin
      bus.o_ram_req_valid = 1'b1;
      bus.o_ram_addr      = {addr_q[ADDR_WIDTH-1:2], 2'b00};
      bus.o_ram_wr_en     = store_q;
      bus.o_ram_wr_mask   = store_q ? storeMask : 4'b0000;
      bus.o_ram_wr_data   = store_q ? (wdata_q << shamt) : '0;
    end
    if (state_q == DONE) begin
      bus.o_lsu_valid    = 1'b1;
      bus.o_lsu_res      = res_q;
      bus.o_lsu_misalign = misalign_q;
    end
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: a table of ops driven against a small memory/WBU responder,
// results checked through a scoreboard queue, plus reset sequences.
module tb_lsu_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;

  logic i_clk;
  logic i_rst;

  lsu_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifc ();

  lsu_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (ifc.slave)
  );

  typedef struct {
    logic        rEn;
    logic        wEn;
    logic [2:0]  byt;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] memWord;
    logic        expReq;
    logic [31:0] expAddr;
    logic [3:0]  expMask;
    logic [31:0] expWrData;
    logic [31:0] expRes;
    logic        expMis;
    int          reqWait;
    int          respWait;
    int          wbuWait;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        mis;
  } exp_t;

  vec_t  vecs[$];
  string vecNames[$];
  exp_t  expQ[$];
  int    checks = 0;
  int    errors = 0;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    ifc.i_exu_valid        = 1'b0;
    ifc.i_idu_ctr_ram_r_en = 1'b0;
    ifc.i_idu_ctr_ram_w_en = 1'b0;
    ifc.i_idu_ctr_ram_byt  = 3'b000;
    ifc.i_exu_res          = '0;
    ifc.i_gpr_rs2_data     = '0;
    ifc.i_ram_req_ready    = 1'b0;
    ifc.i_ram_resp_valid   = 1'b0;
    ifc.i_ram_resp_data    = '0;
    ifc.i_wbu_ready        = 1'b0;
  endtask

  task automatic addVec(input string n, input logic r, input logic w, input logic [2:0] byt,
                        input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] mem,
                        input logic expReq, input logic [31:0] expAddr, input logic [3:0] expMask,
                        input logic [31:0] expWrData, input logic [31:0] expRes, input logic expMis,
                        input int reqWait, input int respWait, input int wbuWait);
    vec_t v;
    v.rEn = r; v.wEn = w; v.byt = byt; v.addr = addr; v.rs2 = rs2; v.memWord = mem;
    v.expReq = expReq; v.expAddr = expAddr; v.expMask = expMask; v.expWrData = expWrData;
    v.expRes = expRes; v.expMis = expMis;
    v.reqWait = reqWait; v.respWait = respWait; v.wbuWait = wbuWait;
    vecs.push_back(v);
    vecNames.push_back(n);
  endtask

  // Drives one op through the DUT, acting as memory and WBU, and checks it end to end.
  task automatic applyStimulus(input string name, input vec_t v);
    int          cyc;
    int          reqCnt, respCnt, wbuCnt;
    bit          reqSeen, validSeen, accepted, reqStable, resStable, readyLowBusy;
    logic [31:0] hAddr, hData, hRes;
    logic [3:0]  hMask;
    logic        hWr, hMis, expWr;
    exp_t        e;
    exp_t        pushed;

    cyc = 0;
    while (!ifc.o_lsu_ready && cyc < 50) begin
      @(posedge i_clk); #1; cyc++;
    end
    checkOutput({name, "_ready_in"}, 32'(ifc.o_lsu_ready), 32'd1);

    ifc.i_exu_valid        = 1'b1;
    ifc.i_idu_ctr_ram_r_en = v.rEn;
    ifc.i_idu_ctr_ram_w_en = v.wEn;
    ifc.i_idu_ctr_ram_byt  = v.byt;
    ifc.i_exu_res          = v.addr;
    ifc.i_gpr_rs2_data     = v.rs2;
    pushed.res = v.expRes;
    pushed.mis = v.expMis;
    expQ.push_back(pushed);
    @(posedge i_clk); #1;
    ifc.i_exu_valid        = 1'b0;
    ifc.i_exu_res          = $urandom;
    ifc.i_gpr_rs2_data     = $urandom;
    ifc.i_idu_ctr_ram_byt  = 3'($urandom);

    expWr = v.wEn & ~v.rEn;
    cyc = 1; reqCnt = 0; respCnt = 0; wbuCnt = 0;
    reqSeen = 0; validSeen = 0; accepted = 0;
    reqStable = 1; resStable = 1; readyLowBusy = 1;
    hAddr = '0; hData = '0; hRes = '0; hMask = '0; hWr = 1'b0; hMis = 1'b0;

    while (!accepted && cyc < 300) begin
      if (ifc.o_lsu_ready) readyLowBusy = 0;

      if (ifc.o_ram_req_valid) begin
        if (!reqSeen) begin
          reqSeen = 1;
          hAddr = ifc.o_ram_addr; hWr = ifc.o_ram_wr_en;
          hMask = ifc.o_ram_wr_mask; hData = ifc.o_ram_wr_data;
          checkOutput({name, "_addr"}, ifc.o_ram_addr, v.expAddr);
          checkOutput({name, "_wr_en"}, 32'(ifc.o_ram_wr_en), 32'(expWr));
          checkOutput({name, "_mask"}, 32'(ifc.o_ram_wr_mask), 32'(v.expMask));
          if (expWr) checkOutput({name, "_wr_data"}, ifc.o_ram_wr_data, v.expWrData);
        end else if (ifc.o_ram_addr !== hAddr || ifc.o_ram_wr_en !== hWr ||
                     ifc.o_ram_wr_mask !== hMask || ifc.o_ram_wr_data !== hData) begin
          reqStable = 0;
        end
        ifc.i_ram_req_ready  = (reqCnt >= v.reqWait);
        reqCnt++;
        // Stray response while the request is pending must be ignored.
        ifc.i_ram_resp_valid = 1'b1;
        ifc.i_ram_resp_data  = 32'h5A5A_A5A5;
      end else begin
        ifc.i_ram_req_ready = 1'b0;
      end

      if (ifc.o_ram_resp_ready) begin
        ifc.i_ram_resp_valid = (respCnt >= v.respWait);
        ifc.i_ram_resp_data  = ifc.i_ram_resp_valid ? v.memWord : 32'h5A5A_A5A5;
        respCnt++;
      end else if (!ifc.o_ram_req_valid) begin
        ifc.i_ram_resp_valid = 1'b0;
      end

      if (ifc.o_lsu_valid) begin
        if (!validSeen) begin
          validSeen = 1;
          hRes = ifc.o_lsu_res; hMis = ifc.o_lsu_misalign;
          checkOutput({name, "_latency"}, 32'(cyc),
                      32'(v.expReq ? 3 + v.reqWait + v.respWait : 1));
          checkOutput({name, "_sb_entry"}, 32'(expQ.size()), 32'd1);
          if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput({name, "_res"}, ifc.o_lsu_res, e.res);
            checkOutput({name, "_misalign"}, 32'(ifc.o_lsu_misalign), 32'(e.mis));
          end
        end else if (ifc.o_lsu_res !== hRes || ifc.o_lsu_misalign !== hMis) begin
          resStable = 0;
        end
        ifc.i_wbu_ready = (wbuCnt >= v.wbuWait);
        accepted = ifc.i_wbu_ready;
        wbuCnt++;
      end else begin
        ifc.i_wbu_ready = 1'b0;
      end

      @(posedge i_clk); #1; cyc++;
    end

    idleInputs();
    checkOutput({name, "_completed"}, 32'(accepted), 32'd1);
    checkOutput({name, "_req_issued"}, 32'(reqSeen), 32'(v.expReq));
    if (reqSeen) checkOutput({name, "_req_stable"}, 32'(reqStable), 32'd1);
    if (validSeen) checkOutput({name, "_res_stable"}, 32'(resStable), 32'd1);
    checkOutput({name, "_ready_low_busy"}, 32'(readyLowBusy), 32'd1);
    checkOutput({name, "_ready_after"}, 32'(ifc.o_lsu_ready), 32'd1);
  endtask

  initial begin
    bit sawValid;

    // name, r, w, byt, addr, rs2, memWord, expReq, expAddr, expMask, expWrData, expRes, expMis, waits
    addVec("LB_1003",      1, 0, 3'b000, 32'h1003, 32'h0,        32'h80FF_1234, 1, 32'h1000, 4'b0000, 32'h0,        32'hFFFF_FF80, 0, 0, 0, 0);
    addVec("LBU_1003",     1, 0, 3'b100, 32'h1003, 32'h0,        32'h80FF_1234, 1, 32'h1000, 4'b0000, 32'h0,        32'h0000_0080, 0, 0, 0, 0);
    addVec("SH_2002",      0, 1, 3'b001, 32'h2002, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1, 32'h2000, 4'b1100, 32'hBEEF_0000, 32'h0,        0, 0, 0, 0);
    addVec("LW_mis_3001",  1, 0, 3'b010, 32'h3001, 32'h0,        32'h0,         0, 32'h0,    4'b0000, 32'h0,        32'h0,         1, 0, 0, 0);
    addVec("LH_1002",      1, 0, 3'b001, 32'h1002, 32'h0,        32'h80FF_1234, 1, 32'h1000, 4'b0000, 32'h0,        32'hFFFF_80FF, 0, 0, 0, 0);
    addVec("LHU_1000",     1, 0, 3'b101, 32'h1000, 32'h0,        32'h80FF_1234, 1, 32'h1000, 4'b0000, 32'h0,        32'h0000_1234, 0, 0, 0, 0);
    addVec("LW_5004",      1, 0, 3'b010, 32'h5004, 32'h0,        32'h1234_5678, 1, 32'h5004, 4'b0000, 32'h0,        32'h1234_5678, 0, 0, 0, 0);
    addVec("LB_1002",      1, 0, 3'b000, 32'h1002, 32'h0,        32'h80FF_1234, 1, 32'h1000, 4'b0000, 32'h0,        32'hFFFF_FFFF, 0, 0, 0, 0);
    addVec("LRW_1001",     1, 1, 3'b000, 32'h1001, 32'hFFFF_FFFF, 32'h80FF_1234, 1, 32'h1000, 4'b0000, 32'h0,        32'h0000_0012, 0, 0, 0, 0);
    addVec("SB_6001",      0, 1, 3'b000, 32'h6001, 32'h0000_00A5, 32'hFFFF_FFFF, 1, 32'h6000, 4'b0010, 32'h0000_A500, 32'h0,        0, 0, 0, 0);
    addVec("SH_1000",      0, 1, 3'b001, 32'h1000, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1, 32'h1000, 4'b0011, 32'hDEAD_BEEF, 32'h0,        0, 0, 0, 0);
    addVec("SW_7000",      0, 1, 3'b010, 32'h7000, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1, 32'h7000, 4'b1111, 32'hCAFE_F00D, 32'h0,        0, 0, 0, 0);
    addVec("SH_mis_2001",  0, 1, 3'b001, 32'h2001, 32'hDEAD_BEEF, 32'h0,         0, 32'h0,    4'b0000, 32'h0,        32'h0,         1, 0, 0, 0);
    addVec("NOP_8000",     0, 0, 3'b010, 32'h8000, 32'h1234_5678, 32'h0,         0, 32'h0,    4'b0000, 32'h0,        32'h0,         0, 0, 0, 0);
    addVec("LX011_9000",   1, 0, 3'b011, 32'h9000, 32'h0,        32'h8765_4321, 1, 32'h9000, 4'b0000, 32'h0,        32'h8765_4321, 0, 0, 0, 0);
    addVec("LX111_mis",    1, 0, 3'b111, 32'h9002, 32'h0,        32'h0,         0, 32'h0,    4'b0000, 32'h0,        32'h0,         1, 0, 0, 0);
    addVec("SB_bp_6003",   0, 1, 3'b000, 32'h6003, 32'h1122_3344, 32'hFFFF_FFFF, 1, 32'h6000, 4'b1000, 32'h4400_0000, 32'h0,        0, 4, 3, 2);
    addVec("LH_bp_1002",   1, 0, 3'b001, 32'h1002, 32'h0,        32'h80FF_1234, 1, 32'h1000, 4'b0000, 32'h0,        32'hFFFF_80FF, 0, 2, 1, 3);

    // Reset held two cycles with every input active.
    i_rst = 1'b1;
    ifc.i_exu_valid        = 1'b1;
    ifc.i_idu_ctr_ram_r_en = 1'b1;
    ifc.i_idu_ctr_ram_w_en = 1'b1;
    ifc.i_idu_ctr_ram_byt  = 3'b010;
    ifc.i_exu_res          = 32'hFFFF_FFFF;
    ifc.i_gpr_rs2_data     = 32'hFFFF_FFFF;
    ifc.i_ram_req_ready    = 1'b1;
    ifc.i_ram_resp_valid   = 1'b1;
    ifc.i_ram_resp_data    = 32'hFFFF_FFFF;
    ifc.i_wbu_ready        = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("rst_lsu_ready", 32'(ifc.o_lsu_ready), 32'd1);
    checkOutput("rst_req_valid", 32'(ifc.o_ram_req_valid), 32'd0);
    checkOutput("rst_resp_ready", 32'(ifc.o_ram_resp_ready), 32'd0);
    checkOutput("rst_lsu_valid", 32'(ifc.o_lsu_valid), 32'd0);
    checkOutput("rst_lsu_res", ifc.o_lsu_res, 32'd0);
    checkOutput("rst_misalign", 32'(ifc.o_lsu_misalign), 32'd0);
    idleInputs();
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecNames[i], vecs[i]);

    // Reset while an LH waits for its response: op is dropped with no result.
    ifc.i_exu_valid        = 1'b1;
    ifc.i_idu_ctr_ram_r_en = 1'b1;
    ifc.i_idu_ctr_ram_byt  = 3'b001;
    ifc.i_exu_res          = 32'h1002;
    @(posedge i_clk); #1;
    idleInputs();
    checkOutput("midrst_req_valid", 32'(ifc.o_ram_req_valid), 32'd1);
    ifc.i_ram_req_ready = 1'b1;
    @(posedge i_clk); #1;
    ifc.i_ram_req_ready = 1'b0;
    checkOutput("midrst_in_resp", 32'(ifc.o_ram_resp_ready), 32'd1);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    checkOutput("midrst_lsu_ready", 32'(ifc.o_lsu_ready), 32'd1);
    checkOutput("midrst_resp_ready", 32'(ifc.o_ram_resp_ready), 32'd0);
    checkOutput("midrst_req_valid_off", 32'(ifc.o_ram_req_valid), 32'd0);
    sawValid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (ifc.o_lsu_valid) sawValid = 1'b1;
      ifc.i_ram_resp_valid = 1'b1;
      ifc.i_ram_resp_data  = 32'h80FF_1234;
      @(posedge i_clk); #1;
    end
    idleInputs();
    checkOutput("midrst_no_result", 32'(sawValid), 32'd0);

    vecs.delete();
    vecNames.delete();
    addVec("LHU_4002_post", 1, 0, 3'b101, 32'h4002, 32'h0, 32'h8001_0000, 1, 32'h4000, 4'b0000, 32'h0, 32'h0000_8001, 0, 0, 0, 0);
    applyStimulus(vecNames[0], vecs[0]);

    checkOutput("sb_drained", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store stage between EXU and WBU. Accepts one memory op per handshake from EXU and drives a valid/ready memory port. Performs byte-lane alignment, store masking, load sign/zero extension and misalignment detection. Presents the aligned load result to WBU as its LSU result with a valid/ready handshake.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width (fixed 4 byte lanes)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_exu_valid  in  1  EXU offers an op
o_lsu_ready  out  1  LSU accepts an op (high only in IDLE)
i_idu_ctr_ram_r_en  in  1  op is a load
i_idu_ctr_ram_w_en  in  1  op is a store
i_idu_ctr_ram_byt  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
i_exu_res  in  ADDR_WIDTH  effective address
i_gpr_rs2_data  in  DATA_WIDTH  store data
o_ram_req_valid  out  1  memory request valid
i_ram_req_ready  in  1  memory accepts request
o_ram_addr  out  ADDR_WIDTH  word-aligned address (low 2 bits zero)
o_ram_wr_en  out  1  request is a write
o_ram_wr_mask  out  4  byte-lane write strobes
o_ram_wr_data  out  DATA_WIDTH  lane-shifted store data
i_ram_resp_valid  in  1  memory response valid
i_ram_resp_data  in  DATA_WIDTH  read word
o_ram_resp_ready  out  1  LSU accepts response (high only in RESP)
o_lsu_valid  out  1  result valid to WBU
i_wbu_ready  in  1  WBU accepts result
o_lsu_res  out  DATA_WIDTH  extended load data; 0 for stores/non-mem ops
o_lsu_misalign  out  1  misaligned access flag, qualified by o_lsu_valid

Behaviour:
- One clock i_clk; i_rst synchronous active-high. Reset: state IDLE, all outputs 0 except o_lsu_ready=1.
- States IDLE, REQ, RESP, DONE. o_lsu_ready = (state==IDLE).
- IDLE: on i_exu_valid, capture addr, data, size, r_en, w_en. Misaligned = (H/HU and addr[0]) or (W and addr[1:0]!=0).
  - No mem op (r_en=w_en=0), or misaligned: go to DONE, res=0, misalign flag set as computed; no memory request issued.
  - r_en and w_en both set is illegal: treated as load.
  - Otherwise go to REQ.
- REQ: o_ram_req_valid=1; address, wr_en, mask, data held stable until i_ram_req_ready. On accept, go to RESP.
- Store mask: B = 1<<addr[1:0]; H = 0011<<addr[1:0]; W = 1111. wr_data = rs2 shifted left by 8*addr[1:0]. Mask is 0000 for loads.
- RESP: o_ram_resp_ready=1. On i_ram_resp_valid:
  - Load: shift word right by 8*addr[1:0], extend per size (B/H sign, BU/HU zero), register into o_lsu_res.
  - Store: response data ignored, res=0.
  - Go to DONE.
- DONE: o_lsu_valid=1, o_lsu_res and o_lsu_misalign stable until i_wbu_ready. On accept, return to IDLE the next cycle; new op is accepted no earlier than that (no same-cycle turnaround).
- Latency: accept to o_lsu_valid minimum 3 cycles for memory ops (IDLE->REQ->RESP->DONE with zero-wait memory); 1 cycle for non-mem/misaligned.
- Response arriving in REQ (before request accept) is ignored.
- Reset mid-transaction: abandon op immediately, return to IDLE, deassert all requests; no result produced.
- Undefined size codes (011, 11x): treated as W.

Test Plan:
- Reset: assert i_rst 2 cycles with all inputs active -> o_lsu_ready=1, o_ram_req_valid=0, o_lsu_valid=0, o_lsu_res=0.
- LB at 0x1003, memory word 0x80FF_1234, zero-wait memory -> o_ram_addr=0x1000, mask 0000, o_lsu_res=0xFFFF_FF80, o_lsu_valid 3 cycles after accept. Repeat with LBU -> 0x0000_0080.
- SH at 0x2002, rs2=0xDEAD_BEEF -> o_ram_addr=0x2000, o_ram_wr_en=1, mask 1100, wr_data=0xBEEF_0000; o_lsu_res=0.
- LW at 0x3001 -> no o_ram_req_valid, o_lsu_valid next cycle with o_lsu_misalign=1, o_lsu_res=0.
- Backpressure: i_ram_req_ready low 4 cycles, then response 3 cycles later, then i_wbu_ready low 2 cycles -> request fields stable throughout REQ, result stable throughout DONE, o_lsu_ready low until one cycle after the WBU accept.
- Reset during RESP of an LH -> next cycle IDLE, o_ram_resp_ready=0, no o_lsu_valid pulse; following LHU at 0x4002 with word 0x8001_0000 -> o_lsu_res=0x0000_8001.
